// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter that shares the PE register-file read mux among NUM_REQ requesters.
// Each access walks IDLE (grant), READ (drive mux), RESP (hold tagged operands until consumed).
module rf_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rs1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rs2,
  input  logic [NUM_REQ-1:0]            req_two,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data1,
  output logic [DATA_WIDTH-1:0]         rsp_data2,
  output logic [ADDR_WIDTH-1:0]         rf_selrs1,
  output logic [ADDR_WIDTH-1:0]         rf_selrs2,
  output logic                          rf_reg_select,
  output logic                          rf_read_en,
  input  logic [DATA_WIDTH-1:0]         rf_data_out1,
  input  logic [DATA_WIDTH-1:0]         rf_data_out2
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                state_q;
  logic [ID_WIDTH-1:0]   lastGrant_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic                  two_q;
  logic [DATA_WIDTH-1:0] data1_q;
  logic [DATA_WIDTH-1:0] data2_q;
  logic [DATA_WIDTH-1:0] data2_d;

  logic                  grantFound;
  logic [ID_WIDTH-1:0]   grantIdx;
  logic [ADDR_WIDTH-1:0] grantRs1;
  logic [ADDR_WIDTH-1:0] grantRs2;
  logic                  grantTwo;

  // Scan upward starting just after the last winner so every requester gets a turn.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(lastGrant_q) + 1 + k) % NUM_REQ;
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = ID_WIDTH'(idx);
      end
    end
  end

  assign grantRs1 = req_rs1[int'(grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign grantRs2 = req_rs2[int'(grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign grantTwo = req_two[grantIdx];

  // Grant is withheld while reset is asserted so no handshake is lost to the reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && grantFound) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  assign data2_d = two_q ? rf_data_out2 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= ID_WIDTH'(NUM_REQ - 1);
      id_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      two_q       <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            rs1_q       <= grantRs1;
            rs2_q       <= grantRs2;
            two_q       <= grantTwo;
            id_q        <= grantIdx;
            lastGrant_q <= grantIdx;
            state_q     <= READ;
          end
        end
        READ: begin
          data1_q <= rf_data_out1;
          data2_q <= data2_d;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = id_q;
  assign rsp_data1     = data1_q;
  assign rsp_data2     = data2_q;
  assign rf_read_en    = (state_q == READ);
  assign rf_selrs1     = rf_read_en ? rs1_q : '0;
  assign rf_selrs2     = rf_read_en ? rs2_q : '0;
  assign rf_reg_select = rf_read_en & two_q;

endmodule
